// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for the 4-bit up/down load counter.
// Optional prediction checker: define COUNTER_PREDICT_CHK_EN.
module counter_seq_ctrl #(
  parameter int MAX_STEPS = 16,
  parameter int STEP_W    = $clog2(MAX_STEPS + 1)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_mode,
  input  logic [3:0]        req_start,
  input  logic [3:0]        req_target,
  output logic [3:0]        cnt_din,
  output logic              cnt_load,
  output logic              cnt_up_down,
  input  logic [3:0]        cnt_count,
  output logic              done,
  output logic              err,
  output logic [STEP_W-1:0] steps,
  output logic              pred_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STEP
  } state_t;

  localparam logic [STEP_W-1:0] MAX_CNT = STEP_W'(MAX_STEPS);

  state_t            state_q, state_d;
  logic [3:0]        start_q, start_d;
  logic [3:0]        target_q, target_d;
  logic              down_q, down_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;

  assign req_ready = resetn && (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    target_d = target_q;
    down_d   = down_q;
    cnt_d    = cnt_q;
    steps_d  = steps_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            (req_mode == 2'b11): begin
              err_d   = 1'b1;
              steps_d = '0;
            end
            default: begin
              state_d  = LOAD;
              target_d = req_target;
              start_d  = (req_mode == 2'b00) ? req_target
                                             : req_start;
              down_d   = (req_mode == 2'b10);
            end
          endcase
        end
      end
      LOAD: begin
        state_d = STEP;
        cnt_d   = '0;
      end
      STEP: begin
        // a match wins over a timeout seen in the same cycle
        if (cnt_count == target_q) begin
          done_d  = 1'b1;
          steps_d = cnt_q;
          state_d = IDLE;
        end else if (cnt_q == MAX_CNT) begin
          err_d   = 1'b1;
          steps_d = MAX_CNT;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + STEP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= IDLE;
      start_q  <= 4'd0;
      target_q <= 4'd0;
      down_q   <= 1'b0;
      cnt_q    <= '0;
      steps_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      target_q <= target_d;
      down_q   <= down_d;
      cnt_q    <= cnt_d;
      steps_q  <= steps_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cnt_load    = (state_q == LOAD);
  assign cnt_din     = cnt_load ? start_q : 4'd0;
  assign cnt_up_down = down_q;
  assign done        = done_q;
  assign err         = err_q;
  assign steps       = steps_q;

`ifdef COUNTER_PREDICT_CHK_EN
  logic [3:0] model_q, model_d;
  logic       perr_q;

  // independent replica of the counter, driven by our own outputs
  always_comb begin
    model_d = model_q;
    if (cnt_load)
      model_d = cnt_din;
    else if (cnt_up_down)
      model_d = (model_q > 4'd10 || model_q < 4'd2) ? 4'd4
                                                   : model_q - 4'd1;
    else
      model_d = (model_q > 4'd12) ? 4'd0 : model_q + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      model_q <= 4'd0;
      perr_q  <= 1'b0;
    end else begin
      model_q <= model_d;
      if (model_q != cnt_count)
        perr_q <= 1'b1;
    end
  end

  assign pred_err = perr_q;
`else
  assign pred_err = 1'b0;
`endif

endmodule
